// File: rtl/ascon_perm_ctrl.sv
// ascon_perm_ctrl: iterative ASCON permutation, one round per clock, valid/ready
// on both sides; owns the 320-bit state register and the round-constant schedule.
module ascon_perm_ctrl #(
    parameter int MAX_ROUNDS = 12,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] in_rounds,
    input  logic [63:0]      in_x0,
    input  logic [63:0]      in_x1,
    input  logic [63:0]      in_x2,
    input  logic [63:0]      in_x3,
    input  logic [63:0]      in_x4,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_x0,
    output logic [63:0]      out_x1,
    output logic [63:0]      out_x2,
    output logic [63:0]      out_x3,
    output logic [63:0]      out_x4,
    output logic             busy,
    output logic [CNT_W-1:0] round_idx
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t           state_q, state_d;
    logic [319:0]     s_q, s_d;
    logic [CNT_W-1:0] r_q, r_d, rem_q, rem_d, n_c;

    function automatic logic [63:0] ror(input logic [63:0] x, input int k);
        return (x >> k) | (x << (64 - k));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [CNT_W-1:0] r);
        logic [3:0]  ri;
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        ri = 4'(r);
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128] ^ {56'd0, ~ri, ri};
        x3 = s[127:64];
        x4 = s[63:0];
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        x2 = x2 ^ ror(x2, 1) ^ ror(x2, 6);
        x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        x4 = x4 ^ ror(x4, 7) ^ ror(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Out-of-range round counts are clamped so the last round is always r = MAX_ROUNDS-1
    assign n_c = (in_rounds == '0) ? CNT_W'(1) :
                 (in_rounds > CNT_W'(MAX_ROUNDS)) ? CNT_W'(MAX_ROUNDS) : in_rounds;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= '0;
            r_q     <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            r_q     <= r_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        r_d     = r_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = RUN;
                s_d     = {in_x0, in_x1, in_x2, in_x3, in_x4};
                r_d     = CNT_W'(MAX_ROUNDS) - n_c;
                rem_d   = n_c;
            end
            RUN: begin
                s_d     = ascon_round(s_q, r_q);
                r_d     = r_q + CNT_W'(1);
                rem_d   = rem_q - CNT_W'(1);
                state_d = (rem_q == CNT_W'(1)) ? HOLD : RUN;
            end
            HOLD: state_d = out_ready ? IDLE : HOLD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == HOLD);
        busy      = (state_q != IDLE);
        round_idx = (state_q == RUN) ? r_q : '0;
    end

    assign {out_x0, out_x1, out_x2, out_x3, out_x4} = s_q;
endmodule
